// File: rtl/rop_frag_serializer.sv
// Serializes one warp-wide ROP request into single fragments, lowest active lane first.
// Define ROP_FRAG_SER_PERF_EN to add the perf_reqs / perf_frags / perf_stalls counters.
`timescale 1ns/1ps
module rop_frag_serializer #(
  parameter int NUM_LANES  = 4,
  parameter int DIM_BITS   = 11,
  parameter int DEPTH_BITS = 24,
  parameter int UUID_WIDTH = 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic [UUID_WIDTH-1:0]           req_uuid,
  input  logic [NUM_LANES-1:0]            req_mask,
  input  logic [NUM_LANES*DIM_BITS-1:0]   req_pos_x,
  input  logic [NUM_LANES*DIM_BITS-1:0]   req_pos_y,
  input  logic [NUM_LANES*32-1:0]         req_color,
  input  logic [NUM_LANES*DEPTH_BITS-1:0] req_depth,
  input  logic [NUM_LANES-1:0]            req_face,
  output logic                            frag_valid,
  input  logic                            frag_ready,
  output logic [UUID_WIDTH-1:0]           frag_uuid,
  output logic [$clog2(NUM_LANES)-1:0]    frag_lane,
  output logic [DIM_BITS-1:0]             frag_pos_x,
  output logic [DIM_BITS-1:0]             frag_pos_y,
  output logic [31:0]                     frag_color,
  output logic [DEPTH_BITS-1:0]           frag_depth,
  output logic                            frag_face,
  output logic                            frag_last,
`ifdef ROP_FRAG_SER_PERF_EN
  output logic [31:0]                     perf_reqs,
  output logic [31:0]                     perf_frags,
  output logic [31:0]                     perf_stalls,
`endif
  output logic                            busy
);

  localparam int LANE_BITS = $clog2(NUM_LANES);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e                          state_q, state_d;
  logic [NUM_LANES-1:0]            rem_q, rem_d;
  logic [UUID_WIDTH-1:0]           uuid_q;
  logic [NUM_LANES*DIM_BITS-1:0]   pos_x_q;
  logic [NUM_LANES*DIM_BITS-1:0]   pos_y_q;
  logic [NUM_LANES*32-1:0]         color_q;
  logic [NUM_LANES*DEPTH_BITS-1:0] depth_q;
  logic [NUM_LANES-1:0]            face_q;

  logic [LANE_BITS-1:0] sel;
  logic [NUM_LANES-1:0] remClr;
  logic                 lastLane;
  logic                 fragFire;
  logic                 reqFire;
  logic                 loadReq;

  // Priority encoder: scanning downward lets the lowest set bit win.
  always_comb begin
    sel = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (rem_q[i]) sel = LANE_BITS'(i);
    end
  end

  assign remClr     = rem_q & ~(NUM_LANES'(1) << sel);
  assign lastLane   = (remClr == '0);
  assign frag_valid = (state_q == BUSY);
  assign busy       = (state_q == BUSY);
  assign frag_last  = lastLane;
  assign fragFire   = frag_valid & frag_ready;
  assign req_ready  = (state_q == IDLE) | (fragFire & lastLane);
  assign reqFire    = req_valid & req_ready;
  assign loadReq    = reqFire & (req_mask != '0);

  // A request accept only happens when the held request is empty or finishing,
  // so it simply overrides the lane clear; a zero mask therefore lands in IDLE.
  always_comb begin
    rem_d = rem_q;
    if (fragFire) rem_d = remClr;
    if (reqFire)  rem_d = req_mask;
    state_d = (rem_d != '0) ? BUSY : IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  always_ff @(posedge clk) begin
    if (loadReq) begin
      uuid_q  <= req_uuid;
      pos_x_q <= req_pos_x;
      pos_y_q <= req_pos_y;
      color_q <= req_color;
      depth_q <= req_depth;
      face_q  <= req_face;
    end
  end

  always_comb begin
    frag_uuid  = uuid_q;
    frag_lane  = sel;
    frag_pos_x = '0;
    frag_pos_y = '0;
    frag_color = '0;
    frag_depth = '0;
    frag_face  = 1'b0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (sel == LANE_BITS'(i)) begin
        frag_pos_x = pos_x_q[i*DIM_BITS +: DIM_BITS];
        frag_pos_y = pos_y_q[i*DIM_BITS +: DIM_BITS];
        frag_color = color_q[i*32 +: 32];
        frag_depth = depth_q[i*DEPTH_BITS +: DEPTH_BITS];
        frag_face  = face_q[i];
      end
    end
  end

`ifdef ROP_FRAG_SER_PERF_EN
  logic [31:0] perfReqs_q, perfFrags_q, perfStalls_q;

  // Free-running wrap-around counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perfReqs_q   <= '0;
      perfFrags_q  <= '0;
      perfStalls_q <= '0;
    end else begin
      if (reqFire)                  perfReqs_q   <= perfReqs_q + 32'd1;
      if (fragFire)                 perfFrags_q  <= perfFrags_q + 32'd1;
      if (frag_valid && !frag_ready) perfStalls_q <= perfStalls_q + 32'd1;
    end
  end

  assign perf_reqs   = perfReqs_q;
  assign perf_frags  = perfFrags_q;
  assign perf_stalls = perfStalls_q;
`endif

endmodule

// File: tb/tb_rop_frag_serializer.sv
// Directed and randomized self-checking bench for rop_frag_serializer (4 lanes, default widths).
// Inputs are driven on the falling edge and outputs sampled 1ns later.
`timescale 1ns/1ps
module tb_rop_frag_serializer;

   logic         clk;
   logic         reset;
   logic         req_valid;
   logic         req_ready;
   logic         req_uuid;
   logic [3:0]   req_mask;
   logic [43:0]  req_pos_x;
   logic [43:0]  req_pos_y;
   logic [127:0] req_color;
   logic [95:0]  req_depth;
   logic [3:0]   req_face;
   logic         frag_valid;
   logic         frag_ready;
   logic         frag_uuid;
   logic [1:0]   frag_lane;
   logic [10:0]  frag_pos_x;
   logic [10:0]  frag_pos_y;
   logic [31:0]  frag_color;
   logic [23:0]  frag_depth;
   logic         frag_face;
   logic         frag_last;
   logic         busy;
`ifdef ROP_FRAG_SER_PERF_EN
   logic [31:0]  perf_reqs;
   logic [31:0]  perf_frags;
   logic [31:0]  perf_stalls;
`endif

   int checks = 0;
   int failures = 0;

   logic [83:0] obsFrag;

   rop_frag_serializer dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_uuid   (req_uuid),
      .req_mask   (req_mask),
      .req_pos_x  (req_pos_x),
      .req_pos_y  (req_pos_y),
      .req_color  (req_color),
      .req_depth  (req_depth),
      .req_face   (req_face),
      .frag_valid (frag_valid),
      .frag_ready (frag_ready),
      .frag_uuid  (frag_uuid),
      .frag_lane  (frag_lane),
      .frag_pos_x (frag_pos_x),
      .frag_pos_y (frag_pos_y),
      .frag_color (frag_color),
      .frag_depth (frag_depth),
      .frag_face  (frag_face),
      .frag_last  (frag_last),
`ifdef ROP_FRAG_SER_PERF_EN
      .perf_reqs  (perf_reqs),
      .perf_frags (perf_frags),
      .perf_stalls(perf_stalls),
`endif
      .busy       (busy)
   );

   // Whole visible fragment packed into one word so a single compare covers it.
   assign obsFrag = {frag_valid, frag_uuid, frag_lane, frag_last, frag_pos_x,
                     frag_pos_y, frag_color, frag_depth, frag_face};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Deterministic per-lane payload for directed requests, keyed by a seed.
   function automatic logic [10:0] laneX(input int seed, input int lane);
      return 11'(seed * 16 + lane + 1);
   endfunction

   function automatic logic [10:0] laneY(input int seed, input int lane);
      return 11'(seed * 16 + lane + 512);
   endfunction

   function automatic logic [31:0] laneColor(input int seed, input int lane);
      return {8'(seed), 8'(lane), 8'hA5, 8'(lane * 3)};
   endfunction

   function automatic logic [23:0] laneDepth(input int seed, input int lane);
      return 24'(seed * 4096 + lane * 17);
   endfunction

   function automatic logic laneFace(input int lane);
      return (lane % 2) == 1;
   endfunction

   function automatic logic [83:0] expFrag(input int seed, input logic uuid, input int lane, input logic last);
      return {1'b1, uuid, 2'(lane), last, laneX(seed, lane), laneY(seed, lane),
              laneColor(seed, lane), laneDepth(seed, lane), laneFace(lane)};
   endfunction

   task automatic driveReq(input logic [3:0] mask, input logic uuid, input int seed);
      req_valid = 1'b1;
      req_mask  = mask;
      req_uuid  = uuid;
      for (int i = 0; i < 4; i++) begin
         req_pos_x[i*11 +: 11] = laneX(seed, i);
         req_pos_y[i*11 +: 11] = laneY(seed, i);
         req_color[i*32 +: 32] = laneColor(seed, i);
         req_depth[i*24 +: 24] = laneDepth(seed, i);
         req_face[i]           = laneFace(i);
      end
   endtask

   task automatic resetDut();
      @(negedge clk);
      reset      = 1'b0;
      req_valid  = 1'b0;
      frag_ready = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   // Reset state both while reset is held and right after release.
   task automatic test_reset();
      reset      = 1'b0;
      req_valid  = 1'b0;
      req_mask   = '0;
      req_uuid   = 1'b0;
      frag_ready = 1'b0;
      req_pos_x  = '0;
      req_pos_y  = '0;
      req_color  = '0;
      req_depth  = '0;
      req_face   = '0;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if ({frag_valid, busy, req_ready} !== 3'b001) begin
         failures++;
         $display("[TB] FAIL reset_held got valid/busy/ready=%b exp=001", {frag_valid, busy, req_ready});
      end
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      #1;
      checks++;
      if ({frag_valid, busy, req_ready} !== 3'b001) begin
         failures++;
         $display("[TB] FAIL reset_released got valid/busy/ready=%b exp=001", {frag_valid, busy, req_ready});
      end
`ifdef ROP_FRAG_SER_PERF_EN
      checks++;
      if ({perf_reqs, perf_frags, perf_stalls} !== 96'd0) begin
         failures++;
         $display("[TB] FAIL reset_perf got %h %h %h exp 0", perf_reqs, perf_frags, perf_stalls);
      end
`endif
   endtask

   // Mask 1011: lanes 0,1,3 with last only on lane 3.
   task automatic test_sparse_mask();
      int lanes[3] = '{0, 1, 3};
      @(negedge clk);
      driveReq(4'b1011, 1'b1, 1);
      frag_ready = 1'b1;
      #1;
      checks++;
      if (req_ready !== 1'b1 || frag_valid !== 1'b0) begin
         failures++;
         $display("[TB] FAIL sparse_accept got ready=%b valid=%b exp ready=1 valid=0", req_ready, frag_valid);
      end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         req_valid = 1'b0;
         #1;
         checks++;
         if (obsFrag !== expFrag(1, 1'b1, lanes[k], k == 2)) begin
            failures++;
            $display("[TB] FAIL sparse_frag%0d got=%h exp=%h", k, obsFrag, expFrag(1, 1'b1, lanes[k], k == 2));
         end
         checks++;
         if (req_ready !== 1'(k == 2)) begin
            failures++;
            $display("[TB] FAIL sparse_ready%0d got=%b exp=%b", k, req_ready, k == 2);
         end
      end
      @(negedge clk);
      #1;
      checks++;
      if (frag_valid !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("[TB] FAIL sparse_idle got valid=%b busy=%b exp 0 0", frag_valid, busy);
      end
   endtask

   // Full mask followed immediately by a lane-2-only request: five valid cycles, no bubble.
   task automatic test_back_to_back();
      @(negedge clk);
      driveReq(4'b1111, 1'b0, 2);
      frag_ready = 1'b1;
      #1;
      checks++;
      if (req_ready !== 1'b1) begin
         failures++;
         $display("[TB] FAIL b2b_accept_a got ready=%b exp=1", req_ready);
      end
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         driveReq(4'b0100, 1'b1, 3);
         #1;
         checks++;
         if (obsFrag !== expFrag(2, 1'b0, k, k == 3)) begin
            failures++;
            $display("[TB] FAIL b2b_frag_a%0d got=%h exp=%h", k, obsFrag, expFrag(2, 1'b0, k, k == 3));
         end
         checks++;
         if (req_ready !== 1'(k == 3)) begin
            failures++;
            $display("[TB] FAIL b2b_ready_a%0d got=%b exp=%b", k, req_ready, k == 3);
         end
      end
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      checks++;
      if (obsFrag !== expFrag(3, 1'b1, 2, 1'b1)) begin
         failures++;
         $display("[TB] FAIL b2b_frag_b got=%h exp=%h", obsFrag, expFrag(3, 1'b1, 2, 1'b1));
      end
      @(negedge clk);
      #1;
      checks++;
      if (frag_valid !== 1'b0 || req_ready !== 1'b1) begin
         failures++;
         $display("[TB] FAIL b2b_idle got valid=%b ready=%b exp 0 1", frag_valid, req_ready);
      end
   endtask

   // Empty mask is consumed without producing a fragment.
   task automatic test_zero_mask();
      @(negedge clk);
      driveReq(4'b0000, 1'b1, 7);
      #1;
      checks++;
      if (req_ready !== 1'b1) begin
         failures++;
         $display("[TB] FAIL zero_accept got ready=%b exp=1", req_ready);
      end
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         req_valid = 1'b0;
         #1;
         checks++;
         if ({frag_valid, busy, req_ready} !== 3'b001) begin
            failures++;
            $display("[TB] FAIL zero_idle%0d got valid/busy/ready=%b exp=001", k, {frag_valid, busy, req_ready});
         end
      end
   endtask

   // Backpressure holds lane 1 stable for three cycles.
   task automatic test_stall();
      resetDut();
      @(negedge clk);
      driveReq(4'b0110, 1'b0, 4);
      frag_ready = 1'b0;
      #1;
      checks++;
      if (req_ready !== 1'b1) begin
         failures++;
         $display("[TB] FAIL stall_accept got ready=%b exp=1", req_ready);
      end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         req_valid  = 1'b0;
         frag_ready = 1'b0;
         #1;
         checks++;
         if (obsFrag !== expFrag(4, 1'b0, 1, 1'b0) || req_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL stall_hold%0d got=%h ready=%b exp=%h ready=0", k, obsFrag, req_ready, expFrag(4, 1'b0, 1, 1'b0));
         end
      end
      @(negedge clk);
      frag_ready = 1'b1;
      #1;
      checks++;
      if (obsFrag !== expFrag(4, 1'b0, 1, 1'b0)) begin
         failures++;
         $display("[TB] FAIL stall_lane1 got=%h exp=%h", obsFrag, expFrag(4, 1'b0, 1, 1'b0));
      end
      @(negedge clk);
      #1;
      checks++;
      if (obsFrag !== expFrag(4, 1'b0, 2, 1'b1) || req_ready !== 1'b1) begin
         failures++;
         $display("[TB] FAIL stall_lane2 got=%h ready=%b exp=%h ready=1", obsFrag, req_ready, expFrag(4, 1'b0, 2, 1'b1));
      end
      @(negedge clk);
      #1;
      checks++;
      if (frag_valid !== 1'b0) begin
         failures++;
         $display("[TB] FAIL stall_idle got valid=%b exp=0", frag_valid);
      end
`ifdef ROP_FRAG_SER_PERF_EN
      checks++;
      if (perf_stalls !== 32'd3 || perf_frags !== 32'd2 || perf_reqs !== 32'd1) begin
         failures++;
         $display("[TB] FAIL stall_perf got stalls=%0d frags=%0d reqs=%0d exp 3 2 1", perf_stalls, perf_frags, perf_reqs);
      end
`endif
   endtask

   // Reset in the middle of a full-mask request drops it immediately.
   task automatic test_reset_mid();
      @(negedge clk);
      driveReq(4'b1111, 1'b1, 5);
      frag_ready = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      checks++;
      if (obsFrag !== expFrag(5, 1'b1, 0, 1'b0)) begin
         failures++;
         $display("[TB] FAIL midrst_lane0 got=%h exp=%h", obsFrag, expFrag(5, 1'b1, 0, 1'b0));
      end
      @(negedge clk);
      reset = 1'b0;
      #1;
      checks++;
      if ({frag_valid, busy, req_ready} !== 3'b001) begin
         failures++;
         $display("[TB] FAIL midrst_assert got valid/busy/ready=%b exp=001", {frag_valid, busy, req_ready});
      end
      @(negedge clk);
      reset = 1'b1;
      driveReq(4'b1000, 1'b0, 6);
      #1;
      checks++;
      if (req_ready !== 1'b1 || frag_valid !== 1'b0) begin
         failures++;
         $display("[TB] FAIL midrst_accept got ready=%b valid=%b exp 1 0", req_ready, frag_valid);
      end
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      checks++;
      if (obsFrag !== expFrag(6, 1'b0, 3, 1'b1)) begin
         failures++;
         $display("[TB] FAIL midrst_lane3 got=%h exp=%h", obsFrag, expFrag(6, 1'b0, 3, 1'b1));
      end
      @(negedge clk);
      #1;
      checks++;
      if (frag_valid !== 1'b0) begin
         failures++;
         $display("[TB] FAIL midrst_idle got valid=%b exp=0", frag_valid);
      end
   endtask

   // Random masks and backpressure against a transaction-level reference model.
   task automatic test_random();
      int          generated = 0;
      int          cycles = 0;
      int          nonzero = 0;
      int          lasts = 0;
      int          sel;
      logic        pend = 1'b0;
      logic [3:0]  pMask = '0;
      logic        pUuid = 1'b0;
      logic [10:0] px[4], py[4], hx[4], hy[4];
      logic [31:0] pc[4], hc[4];
      logic [23:0] pd[4], hd[4];
      logic [3:0]  pf = '0, hf = '0;
      logic        hUuid = 1'b0;
      logic [3:0]  mRem = '0;
      logic        expLast, expReady;
      logic [83:0] exp;
      resetDut();
      while ((generated < 10000 || pend || mRem != 4'b0) && cycles < 80000) begin
         @(negedge clk);
         cycles++;
         if (!pend && generated < 10000 && $urandom_range(0, 3) != 0) begin
            pend = 1'b1;
            generated++;
            pMask = 4'($urandom_range(0, 15));
            pUuid = 1'($urandom_range(0, 1));
            for (int i = 0; i < 4; i++) begin
               px[i] = 11'($urandom);
               py[i] = 11'($urandom);
               pc[i] = $urandom;
               pd[i] = 24'($urandom);
               pf[i] = 1'($urandom_range(0, 1));
            end
         end
         req_valid = pend;
         req_mask  = pMask;
         req_uuid  = pUuid;
         req_face  = pf;
         for (int i = 0; i < 4; i++) begin
            req_pos_x[i*11 +: 11] = px[i];
            req_pos_y[i*11 +: 11] = py[i];
            req_color[i*32 +: 32] = pc[i];
            req_depth[i*24 +: 24] = pd[i];
         end
         frag_ready = ($urandom_range(0, 3) != 0);
         #1;
         sel = 0;
         for (int i = 3; i >= 0; i--) if (mRem[i]) sel = i;
         expLast  = ((mRem & ~(4'b0001 << sel)) == 4'b0);
         expReady = (mRem == 4'b0) || (frag_ready && expLast);
         checks++;
         if (req_ready !== expReady) begin
            failures++;
            $display("[TB] FAIL rand_ready cycle=%0d got=%b exp=%b", cycles, req_ready, expReady);
         end
         checks++;
         if (mRem != 4'b0) begin
            exp = {1'b1, hUuid, 2'(sel), expLast, hx[sel], hy[sel], hc[sel], hd[sel], hf[sel]};
            if (obsFrag !== exp) begin
               failures++;
               $display("[TB] FAIL rand_frag cycle=%0d got=%h exp=%h", cycles, obsFrag, exp);
            end
         end else if (frag_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rand_idle cycle=%0d got valid=%b exp=0", cycles, frag_valid);
         end
         if (frag_valid === 1'b1 && frag_ready && frag_last === 1'b1) lasts++;
         if (mRem != 4'b0 && frag_ready) mRem[sel] = 1'b0;
         if (pend && expReady) begin
            pend = 1'b0;
            mRem = pMask;
            if (pMask != 4'b0) nonzero++;
            hUuid = pUuid;
            hf    = pf;
            for (int i = 0; i < 4; i++) begin
               hx[i] = px[i];
               hy[i] = py[i];
               hc[i] = pc[i];
               hd[i] = pd[i];
            end
         end
      end
      req_valid = 1'b0;
      checks++;
      if (cycles >= 80000) begin
         failures++;
         $display("[TB] FAIL rand_timeout got generated=%0d exp=10000 within 80000 cycles", generated);
      end
      checks++;
      if (lasts != nonzero) begin
         failures++;
         $display("[TB] FAIL rand_last_count got=%0d exp=%0d", lasts, nonzero);
      end
   endtask

   initial begin
      test_reset();
      test_sparse_mask();
      test_back_to_back();
      test_zero_mask();
      test_stall();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #5000000;
      $display("[TB] FAIL watchdog got timeout exp completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/rop_frag_serializer.md
Name: rop_frag_serializer

Overview:
- Sits directly downstream of the per-core ROP agent request skid buffer and upstream of the ROP unit's single-fragment input port.
- Accepts one warp-wide ROP request (up to NUM_LANES fragments with a lane mask) and emits the active lanes one fragment per cycle, lowest lane index first.
- Tags each fragment with uuid, lane index and a last flag so the ROP unit can track request completion.

Parameters:
- NUM_LANES, 4, lanes per request (power of two, >=2)
- DIM_BITS, 11, width of pos_x / pos_y
- DEPTH_BITS, 24, width of depth
- UUID_WIDTH, 1, width of the request uuid tag

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when valid&&ready
- req_uuid  in  UUID_WIDTH  request tag
- req_mask  in  NUM_LANES  active-lane mask
- req_pos_x  in  NUM_LANES*DIM_BITS  per-lane x
- req_pos_y  in  NUM_LANES*DIM_BITS  per-lane y
- req_color  in  NUM_LANES*32  per-lane RGBA8
- req_depth  in  NUM_LANES*DEPTH_BITS  per-lane depth
- req_face  in  NUM_LANES  per-lane backface bit
- frag_valid  out  1  fragment valid
- frag_ready  in  1  fragment accepted when valid&&ready
- frag_uuid  out  UUID_WIDTH  tag of originating request
- frag_lane  out  log2(NUM_LANES)  source lane index
- frag_pos_x, frag_pos_y  out  DIM_BITS each  fragment position
- frag_color  out  32  fragment color
- frag_depth  out  DEPTH_BITS  fragment depth
- frag_face  out  1  fragment face bit
- frag_last  out  1  final fragment of the request
- busy  out  1  request held (state BUSY)

Behaviour:
- Storage: one request holding register (uuid, all lane data) plus a remaining-lane mask rem[NUM_LANES].
- States: IDLE (rem==0, nothing held) and BUSY (rem!=0).
- Reset (reset==0, async): state=IDLE, rem=0, frag_valid=0, busy=0, req_ready=1. Data registers need not be reset. A request or fragment in flight at reset assertion is discarded with no output.
- req_ready = IDLE || (frag_valid && frag_ready && frag_last). This is the only ready/valid combinational path.
- Output is a registered-state decode; no combinational path from req_* to frag_*. Latency from accept at cycle T to first frag_valid is T+1.
- Current lane: sel = index of the lowest set bit of rem.
  - frag_lane = sel; frag_* data are lane sel of the held register.
  - frag_last = (rem with bit sel cleared) == 0.
- On frag handshake: clear rem[sel].
  - If frag_last and req_valid: load the new request in the same cycle. No bubble, so a back-to-back full-mask stream gives 100% output utilisation.
  - If frag_last and !req_valid: go to IDLE.
- Accepting a request with req_mask==0 loads nothing, stays IDLE and emits no fragment. req_ready stays 1.
- frag_valid = BUSY. Once asserted, it and all frag_* stay stable until the handshake (AXI-style; no retraction).
- Simultaneous last-fragment handshake and new request accept in the same cycle is legal and required, as above.
- busy = BUSY.

Optional Feature:
- Macro: ROP_FRAG_SER_PERF_EN.
- Defined: adds outputs perf_reqs (32), perf_frags (32) and perf_stalls (32).
  - perf_reqs counts accepted requests, including mask==0.
  - perf_frags counts fragment handshakes.
  - perf_stalls counts cycles with frag_valid && !frag_ready.
  - All counters reset to 0 and wrap modulo 2^32.
- Undefined: these ports and counters do not exist. Functional behaviour is identical.

Test Plan:
- Reset, then mask=4'b1011, uuid=1, frag_ready=1 -> fragments lane 0,1,3 on cycles T+1..T+3. frag_last=1 only on lane 3; req_ready=0 during cycles T+1..T+2.
- Two back-to-back requests, masks 4'b1111 then 4'b0100, frag_ready=1 -> 5 consecutive valid cycles with no bubble. Second request accepted on the cycle lane 3 of the first handshakes.
- mask=4'b0000 request -> accepted in 1 cycle, no frag_valid, state stays IDLE.
- mask=4'b0110, frag_ready low for 3 cycles -> lane 1 fragment held stable for 3 cycles, then lanes 1 and 2 emitted. With ROP_FRAG_SER_PERF_EN: perf_stalls=3, perf_frags=2, perf_reqs=1.
- Assert reset mid-request after lane 0 of mask=4'b1111 -> frag_valid=0 and req_ready=1 immediately. After release, a new mask=4'b1000 request yields a single fragment, lane 3, with frag_last=1.
- Random masks and random frag_ready over 10k requests -> scoreboard matches lane order and data per uuid, and exactly one frag_last per nonzero-mask request.
